// File: rtl/ws2812b_rx_decoder.sv
// WS2812B receive decoder: pulse-width bit slicer, 24-bit packer, frame gap detect.
// Optional daisy-chain forwarding is built when WS2812B_RX_FWD_EN is defined.
module ws2812b_rx_decoder #(
    parameter int BIT_THRESH = 120,
    parameter int MIN_HIGH   = 20,
    parameter int MAX_HIGH   = 240,
    parameter int RESET_LOW  = 10000,
    parameter int MAX_PIXELS = 123
) (
    input  logic        clk_200,
    input  logic        restn,
    input  logic        ws_in,
    output logic [23:0] RGB_data,
    output logic        RGB_valid,
    output logic        frame_end,
    output logic [7:0]  frame_pixels,
    output logic        err,
    output logic        ws_out
);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        LOW,
        HIGH
    } state_t;

    localparam logic [13:0] HTH = 14'(BIT_THRESH);
    localparam logic [13:0] HMN = 14'(MIN_HIGH);
    localparam logic [13:0] HMX = 14'(MAX_HIGH - 1);
    localparam logic [13:0] LRS = 14'(RESET_LOW - 1);
    localparam logic [7:0]  PMX = 8'(MAX_PIXELS);

    state_t      state;
    logic        s1;
    logic        ws_s;
    logic [13:0] hcnt;
    logic [13:0] lcnt;
    logic [23:0] shreg;
    logic [23:0] word;
    logic [4:0]  bit_cnt;
    logic [7:0]  pix_cnt;
    logic        h_abort;
    logic        h_last;

    function automatic logic [13:0] sat_inc(input logic [13:0] c);
        return (c == 14'h3fff) ? c : c + 14'd1;
    endfunction

    // Bit value and packed word for the pulse that is ending now.
    assign word = {shreg[22:0], (hcnt >= HTH)};

    // Pulse in HIGH is rejected: too long while still high, or too short at its fall.
    assign h_abort = (state == HIGH) &&
                     (ws_s ? (hcnt == HMX) : (hcnt < HMN));

    // Falling edge that completes the 24th bit of a pixel.
    assign h_last = (state == HIGH) && !ws_s && !h_abort &&
                    (bit_cnt == 5'd23);

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk_200) begin
        if (!restn) begin
            s1   <= 1'b0;
            ws_s <= 1'b0;
        end else begin
            s1   <= ws_in;
            ws_s <= s1;
        end
    end

    // Decode FSM: pulse measurement, bit packing, frame gap and error strobes.
    always_ff @(posedge clk_200) begin
        if (!restn) begin
            state        <= SYNC;
            hcnt         <= '0;
            lcnt         <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            RGB_data     <= '0;
            RGB_valid    <= 1'b0;
            frame_end    <= 1'b0;
            frame_pixels <= '0;
            err          <= 1'b0;
        end else begin
            RGB_valid <= 1'b0;
            frame_end <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                SYNC: begin
                    if (ws_s) begin
                        lcnt <= '0;
                    end else if (lcnt == LRS) begin
                        state <= IDLE;
                    end else begin
                        lcnt <= sat_inc(lcnt);
                    end
                end
                IDLE: begin
                    if (ws_s) begin
                        state <= HIGH;
                        hcnt  <= 14'd1;
                    end
                end
                LOW: begin
                    if (ws_s) begin
                        state <= HIGH;
                        hcnt  <= 14'd1;
                    end else if (lcnt == LRS) begin
                        frame_end    <= 1'b1;
                        frame_pixels <= pix_cnt;
                        err          <= (bit_cnt != 5'd0);
                        bit_cnt      <= '0;
                        pix_cnt      <= '0;
                        state        <= IDLE;
                    end else begin
                        lcnt <= sat_inc(lcnt);
                    end
                end
                HIGH: begin
                    if (h_abort) begin
                        err     <= 1'b1;
                        state   <= SYNC;
                        lcnt    <= '0;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                    end else if (ws_s) begin
                        hcnt <= sat_inc(hcnt);
                    end else begin
                        shreg <= word;
                        lcnt  <= '0;
                        state <= LOW;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            if (pix_cnt < PMX) begin
                                RGB_data  <= word;
                                RGB_valid <= 1'b1;
                                pix_cnt   <= pix_cnt + 8'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef WS2812B_RX_FWD_EN
    logic first_pix;

    // Marks the first pixel of a frame, which is consumed here and not forwarded.
    always_ff @(posedge clk_200) begin
        if (!restn) begin
            first_pix <= 1'b0;
        end else if (state == IDLE && ws_s) begin
            first_pix <= 1'b1;
        end else if (h_abort || h_last) begin
            first_pix <= 1'b0;
        end
    end

    // IDLE is masked too so the rising edge that starts pixel one never leaks.
    assign ws_out = ws_s & ~(first_pix | (state == IDLE));
`else
    assign ws_out = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Scoreboard bench for ws2812b_rx_decoder with scaled pulse timing.
// Forwarding checks are built when WS2812B_RX_FWD_EN is defined.
module tb_ws2812b_rx_decoder;

    localparam int TH1 = 12;
    localparam int TL1 = 6;
    localparam int TH0 = 6;
    localparam int TL0 = 12;
    localparam int GAP = 150;

    logic        clk_200 = 1'b0;
    logic        restn = 1'b0;
    logic        ws_in = 1'b0;
    logic [23:0] RGB_data;
    logic        RGB_valid;
    logic        frame_end;
    logic [7:0]  frame_pixels;
    logic        err;
    logic        ws_out;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_fe = 0;
    int n_wsout = 0;
    int fwd_mode = 0;
    int fwd_bad = 0;
    logic [7:0] fe_pix = '0;
    logic fe_err = 1'b0;
    logic ws_prev = 1'b0;
    logic [23:0] exp_q[$];

    always #5 clk_200 = ~clk_200;

    ws2812b_rx_decoder #(
        .BIT_THRESH(9),
        .MIN_HIGH(3),
        .MAX_HIGH(18),
        .RESET_LOW(100),
        .MAX_PIXELS(123)
    ) dut (
        .clk_200(clk_200),
        .restn(restn),
        .ws_in(ws_in),
        .RGB_data(RGB_data),
        .RGB_valid(RGB_valid),
        .frame_end(frame_end),
        .frame_pixels(frame_pixels),
        .err(err),
        .ws_out(ws_out)
    );

    task automatic tick();
        logic [23:0] e;
        @(posedge clk_200);
        #1;
        if (RGB_valid) begin
            n_valid++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rgb_unexpected got=%h", RGB_data);
            end else begin
                e = exp_q.pop_front();
                if (RGB_data !== e) begin
                    bad++;
                    $display("FAIL rgb_data got=%h want=%h", RGB_data, e);
                end
            end
            if (err) begin
                bad++;
                $display("FAIL err_with_valid got=1 want=0");
            end
        end
        if (err) n_err++;
        if (frame_end) begin
            n_fe++;
            fe_pix = frame_pixels;
            fe_err = err;
        end
        if (ws_out) n_wsout++;
        if (fwd_mode == 1 && ws_out !== 1'b0) fwd_bad++;
        if (fwd_mode == 2 && ws_out !== ws_prev) fwd_bad++;
        ws_prev = ws_in;
    endtask

    task automatic hold(input logic v, input int n);
        ws_in = v;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        hold(1'b1, b ? TH1 : TH0);
        hold(1'b0, b ? TL1 : TL0);
    endtask

    task automatic send_pixel(input logic [23:0] d, input logic push);
        if (push) exp_q.push_back(d);
        for (int i = 23; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic test_reset();
        restn = 1'b0;
        for (int i = 0; i < 6; i++) hold(i[0], 3);
        total++;
        if ({RGB_data, RGB_valid, frame_end, frame_pixels, err, ws_out} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {RGB_data, RGB_valid, frame_end, frame_pixels, err, ws_out});
        end
        restn = 1'b1;
        hold(1'b0, GAP);
    endtask

    task automatic test_frame();
        int v0 = n_valid;
        int f0 = n_fe;
        int e0 = n_err;
        logic [23:0] d = 24'hA53C0F;
        exp_q.push_back(d);
        for (int i = 23; i >= 1; i--) send_bit(d[i]);
        hold(1'b1, TH1);
        ws_in = 1'b0;
        tick();
        tick();
        total++;
        if (RGB_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early got=%b want=0", RGB_valid);
        end
        tick();
        total++;
        if (RGB_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency_3clk got=%b want=1", RGB_valid);
        end
        hold(1'b0, GAP);
        total++;
        if (n_valid - v0 !== 1) begin
            bad++;
            $display("FAIL t1_valid_count got=%0d want=1", n_valid - v0);
        end
        total++;
        if (n_fe - f0 !== 1 || fe_pix !== 8'd1 || fe_err !== 1'b0) begin
            bad++;
            $display("FAIL t1_frame got fe=%0d pix=%0d err=%b want 1 1 0",
                     n_fe - f0, fe_pix, fe_err);
        end
        total++;
        if (n_err - e0 !== 0) begin
            bad++;
            $display("FAIL t1_err got=%0d want=0", n_err - e0);
        end
        total++;
        if (RGB_data !== 24'hA53C0F) begin
            bad++;
            $display("FAIL t1_hold got=%h want=a53c0f", RGB_data);
        end
    endtask

    task automatic test_midstream_reset();
        int v0 = n_valid;
        int f0 = n_fe;
        restn = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i == 10) restn = 1'b1;
            send_bit(1'($urandom_range(0, 1)));
        end
        hold(1'b0, GAP);
        total++;
        if (n_valid - v0 !== 0 || n_fe - f0 !== 0) begin
            bad++;
            $display("FAIL t2_locked_midframe got v=%0d fe=%0d want 0 0",
                     n_valid - v0, n_fe - f0);
        end
        send_pixel(24'h00FF00, 1'b1);
        hold(1'b0, GAP);
        total++;
        if (n_valid - v0 !== 1 || n_fe - f0 !== 1 || fe_pix !== 8'd1) begin
            bad++;
            $display("FAIL t2_recover got v=%0d fe=%0d pix=%0d want 1 1 1",
                     n_valid - v0, n_fe - f0, fe_pix);
        end
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_fe;
        int e0 = n_err;
        logic [23:0] d = 24'hC3C3C3;
        for (int i = 23; i >= 16; i--) send_bit(d[i]);
        hold(1'b1, 2);
        hold(1'b0, TL0);
        for (int i = 15; i >= 0; i--) send_bit(d[i]);
        hold(1'b0, GAP);
        total++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0 || n_fe - f0 !== 0) begin
            bad++;
            $display("FAIL t3_glitch got e=%0d v=%0d fe=%0d want 1 0 0",
                     n_err - e0, n_valid - v0, n_fe - f0);
        end
        send_pixel(24'h5A5A5A, 1'b1);
        hold(1'b0, GAP);
        total++;
        if (n_valid - v0 !== 1 || n_fe - f0 !== 1 || n_err - e0 !== 1) begin
            bad++;
            $display("FAIL t3_recover got v=%0d fe=%0d e=%0d want 1 1 1",
                     n_valid - v0, n_fe - f0, n_err - e0);
        end
    endtask

    task automatic test_partial();
        int v0 = n_valid;
        int f0 = n_fe;
        int e0 = n_err;
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        hold(1'b0, GAP);
        total++;
        if (n_fe - f0 !== 1 || fe_err !== 1'b1 || fe_pix !== 8'd0) begin
            bad++;
            $display("FAIL t4_partial got fe=%0d err=%b pix=%0d want 1 1 0",
                     n_fe - f0, fe_err, fe_pix);
        end
        total++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin
            bad++;
            $display("FAIL t4_counts got v=%0d e=%0d want 0 1",
                     n_valid - v0, n_err - e0);
        end
    endtask

    task automatic test_stuck_high();
        int f0 = n_fe;
        int e0 = n_err;
        hold(1'b1, 30);
        hold(1'b0, GAP);
        total++;
        if (n_err - e0 !== 1 || n_fe - f0 !== 0) begin
            bad++;
            $display("FAIL stuck_high got e=%0d fe=%0d want 1 0",
                     n_err - e0, n_fe - f0);
        end
    endtask

    task automatic test_overflow();
        int v0 = n_valid;
        int e0 = n_err;
        for (int p = 1; p <= 123; p++) send_pixel(24'(p), 1'b1);
        total++;
        if (n_err - e0 !== 0) begin
            bad++;
            $display("FAIL t5_early_err got=%0d want=0", n_err - e0);
        end
        send_pixel(24'd124, 1'b0);
        hold(1'b0, GAP);
        total++;
        if (n_valid - v0 !== 123 || n_err - e0 !== 1) begin
            bad++;
            $display("FAIL t5_counts got v=%0d e=%0d want 123 1",
                     n_valid - v0, n_err - e0);
        end
        total++;
        if (fe_pix !== 8'd123 || fe_err !== 1'b0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL t5_frame got pix=%0d err=%b q=%0d want 123 0 0",
                     fe_pix, fe_err, exp_q.size());
        end
    endtask

    task automatic test_forward();
`ifdef WS2812B_RX_FWD_EN
        int w0;
        fwd_bad = 0;
        fwd_mode = 1;
        send_pixel(24'hFFFFFF, 1'b1);
        fwd_mode = 2;
        w0 = n_wsout;
        send_pixel(24'h000000, 1'b1);
        hold(1'b0, GAP);
        fwd_mode = 0;
        total++;
        if (fwd_bad !== 0 || n_wsout - w0 !== 24 * TH0) begin
            bad++;
            $display("FAIL t6_forward got bad=%0d high=%0d want 0 %0d",
                     fwd_bad, n_wsout - w0, 24 * TH0);
        end
        total++;
        if (fe_pix !== 8'd2) begin
            bad++;
            $display("FAIL t6_frame got pix=%0d want 2", fe_pix);
        end
`else
        total++;
        if (n_wsout !== 0) begin
            bad++;
            $display("FAIL ws_out_tied got=%0d want=0", n_wsout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midstream_reset();
        test_glitch();
        test_partial();
        test_stuck_high();
        test_overflow();
        test_forward();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
